// File: rtl/race_sequencer.sv
// race_sequencer
// Drives an arbiter-PUF style ring-oscillator race, one race per response bit.
// For each bit it selects an oscillator pair, holds the counters and arbiter
// cleared for a settle period, and then releases the race. The synchronized
// winner, or a forced 0 if the race times out, is presented on a
// valid/ready handshake.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle request; honored only in IDLE
//   challenge    base oscillator-pair index, latched on start
//   ro_sel       pair select = challenge + bit index (mod 2^SEL_WIDTH)
//   ro_en        enables selected oscillators and counters during the race
//   race_clear   clears race counters and holds the arbiter in reset
//   arb_done     arbiter done (asynchronous, synchronized here)
//   arb_out      arbiter winner (asynchronous, synchronized here)
//   resp_bit     response bit
//   resp_valid   resp_bit valid
//   resp_ready   consumer accepts resp_bit when resp_valid is high
//   resp_last    final bit of the response
//   busy         not in IDLE
//   timeout_err  sticky: some race in this response timed out
//
// state   | meaning
// IDLE    | waiting for start; arbiter held cleared
// SETUP   | pair selected, counters and arbiter held cleared SETTLE_CYCLES cycles
// RACE    | oscillators running, waiting for arbiter done or timeout
// PRESENT | bit on the handshake, waiting for resp_ready
module race_sequencer #(
  parameter int NUM_BITS       = 16,
  parameter int SEL_WIDTH      = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] challenge,
  output logic [SEL_WIDTH-1:0] ro_sel,
  output logic                 ro_en,
  output logic                 race_clear,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic                 resp_bit,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_last,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int SET_W = 8;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BITS - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT   = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    RACE    = 2'd2,
    PRESENT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 done_meta_q, done_s_q;
  logic                 out_meta_q, out_s_q;
  logic [SEL_WIDTH-1:0] chal_q, chal_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [TMO_W-1:0]     tmo_next;
  logic                 bit_q, bit_d;
  logic                 err_q, err_d;

  // Two-flop synchronizers for the arbiter outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      out_meta_q  <= 1'b0;
      out_s_q     <= 1'b0;
    end else begin
      done_meta_q <= arb_done;
      done_s_q    <= done_meta_q;
      out_meta_q  <= arb_out;
      out_s_q     <= out_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      chal_q   <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      bit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    bit_d    = bit_q;
    err_d    = err_q;
    tmo_next = tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          chal_d   = challenge;
          idx_d    = '0;
          err_d    = 1'b0;
          settle_d = SETTLE_LOAD;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // Settle down-counter was loaded with SETTLE_CYCLES-1 on entry.
        if (settle_q == '0) begin
          tmo_d   = '0;
          state_d = RACE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      RACE: begin
        tmo_d = tmo_next;
        // done_s is checked first so that a done arriving on the timeout
        // cycle wins and no error is flagged.
        if (done_s_q) begin
          bit_d   = out_s_q;
          state_d = PRESENT;
        end else if (tmo_next == TMO_LIMIT) begin
          bit_d   = 1'b0;
          err_d   = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (resp_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d    = idx_q + 1'b1;
            settle_d = SETTLE_LOAD;
            state_d  = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // chal_q and idx_q change only on start (IDLE) and on acceptance
  // (PRESENT), so the select stays stable from SETUP through PRESENT.
  assign ro_sel      = chal_q + SEL_WIDTH'(idx_q);
  assign ro_en       = (state_q == RACE);
  assign race_clear  = (state_q != RACE);
  assign resp_valid  = (state_q == PRESENT);
  assign resp_last   = (state_q == PRESENT) && (idx_q == LAST_IDX);
  assign resp_bit    = bit_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Randomized bench for race_sequencer. An arbiter model raises arb_done
// a planned number of cycles into each race, or never raises it. The
// expected bits, select sequence, race lengths and sticky error are derived
// from that per-bit plan.
module tb_race_sequencer;

  localparam int NB     = 16;
  localparam int SW     = 4;
  localparam int SETTLE = 4;
  localparam int TMO    = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] challenge = '0;
  logic          arb_done = 1'b0;
  logic          arb_out = 1'b0;
  logic          resp_ready = 1'b0;
  logic [SW-1:0] ro_sel;
  logic          ro_en, race_clear, resp_bit, resp_valid, resp_last, busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-bit arbiter plan: done delay in race cycles, winner, never-done.
  int dly   [NB];
  bit win   [NB];
  bit never [NB];

  always #5 clk = ~clk;

  race_sequencer #(
    .NUM_BITS(NB), .SEL_WIDTH(SW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .ro_sel(ro_sel), .ro_en(ro_en), .race_clear(race_clear),
    .arb_done(arb_done), .arb_out(arb_out),
    .resp_bit(resp_bit), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_last(resp_last), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_ro_en",       int'(ro_en),       0);
    chk("rst_race_clear",  int'(race_clear),  1);
    chk("rst_resp_valid",  int'(resp_valid),  0);
    chk("rst_resp_last",   int'(resp_last),   0);
    chk("rst_resp_bit",    int'(resp_bit),    0);
    chk("rst_busy",        int'(busy),        0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_ro_sel",      int'(ro_sel),      0);
  endtask

  task automatic plan_random();
    for (int i = 0; i < NB; i++) begin
      dly[i]   = int'($urandom_range(2, 20));
      win[i]   = 1'($urandom);
      never[i] = 1'b0;
    end
  endtask

  // One full response. stall_bit/stall_len hold resp_ready low in PRESENT,
  // junk pulses start mid-race, rst_bit (>=0) resets during that bit's race.
  task automatic run_resp(input int chal, input int stall_bit, input int stall_len,
                          input bit junk, input int rst_bit);
    bit exp_err;
    int sc, rc, stall, exp_sel;
    exp_err = 1'b0;
    @(negedge clk);
    start = 1'b1;
    challenge = SW'(chal);
    @(negedge clk);
    start = 1'b0;
    challenge = SW'($urandom);
    chk("busy_on_start", int'(busy), 1);
    chk("err_cleared_on_start", int'(timeout_err), 0);
    for (int i = 0; i < NB; i++) begin
      exp_sel = (chal + i) % 16;
      chk("sel_setup", int'(ro_sel), exp_sel);
      sc = 0;
      while (!ro_en && sc < 100) begin
        sc++;
        @(negedge clk);
      end
      chk("setup_len", sc, SETTLE);

      rc = 0;
      while (ro_en && rc < TMO + 50) begin
        rc++;
        if (rc == 1) begin
          chk("sel_race", int'(ro_sel), exp_sel);
          chk("race_clear_low", int'(race_clear), 0);
        end
        if (!never[i] && rc == dly[i]) begin
          arb_out  = win[i];
          arb_done = 1'b1;
        end
        start = junk && (rc == 3);
        if (junk && rc == 3) challenge = SW'($urandom);
        if (i == rst_bit && rc == 3) begin
          reset = 1'b0;
          start = 1'b0;
          #1;
          check_reset_vals();
          arb_done = 1'b0;
          repeat (3) @(negedge clk);
          check_reset_vals();
          reset = 1'b1;
          return;
        end
        @(negedge clk);
      end
      start = 1'b0;
      chk("race_len", rc, never[i] ? TMO : dly[i] + 2);

      if (never[i]) exp_err = 1'b1;
      arb_done = 1'b0;
      stall = (i == stall_bit) ? stall_len : 0;
      forever begin
        chk("resp_valid",   int'(resp_valid),  1);
        chk("resp_bit",     int'(resp_bit),    never[i] ? 0 : int'(win[i]));
        chk("resp_last",    int'(resp_last),   int'(i == NB - 1));
        chk("sel_present",  int'(ro_sel),      exp_sel);
        chk("ro_en_present", int'(ro_en),      0);
        chk("timeout_err",  int'(timeout_err), int'(exp_err));
        if (stall == 0) break;
        resp_ready = 1'b0;
        stall--;
        @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'($urandom);
    end
    chk("idle_after_last", int'(busy), 0);
    chk("valid_after_last", int'(resp_valid), 0);
    chk("err_held_in_idle", int'(timeout_err), int'(exp_err));
  endtask

  initial begin
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // All bits 1, arbiter done ten cycles into each race.
    for (int i = 0; i < NB; i++) begin
      dly[i] = 10; win[i] = 1'b1; never[i] = 1'b0;
    end
    run_resp(3, -1, 0, 1'b0, -1);

    // Alternating winners; bit 2 held 20 cycles in PRESENT.
    plan_random();
    for (int i = 0; i < NB; i++) win[i] = (i % 2 == 0);
    run_resp(int'($urandom_range(0, 15)), 2, 20, 1'b0, -1);

    // Bit 5 never completes: forced 0 and sticky error.
    plan_random();
    never[5] = 1'b1;
    run_resp(int'($urandom_range(0, 15)), -1, 0, 1'b0, -1);

    // start pulsed while busy, wrap from challenge 15.
    plan_random();
    run_resp(15, int'($urandom_range(0, 15)), int'($urandom_range(1, 5)), 1'b1, -1);

    // Reset during bit 7 race, then a full clean response.
    plan_random();
    run_resp(int'($urandom_range(0, 15)), -1, 0, 1'b0, 7);
    plan_random();
    run_resp(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 3, 1'b0, -1);

    for (int k = 0; k < 3; k++) begin
      plan_random();
      run_resp(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 6)), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
